mic_dma_multi: RTL and testbench
================================

Name: mic_dma_multi

Overview:
- Parametrised successor to the two-microphone capture DMA.
- Per frame, steps the mic mux through NUM_CH channels, captures one DATA_W word per channel, and writes each word through an Avalon-MM master into a per-channel contiguous buffer.
- Sits between the mic array front end (mic_data/select/read_ready) and the HPS-side SDRAM bridge, controlled by the slave register block (start, start_address, number_samples, FINISHED).

Parameters:
- NUM_CH, 4, number of mic channels; 2..8.
- ADDR_W, 32, Avalon address width (byte addresses).
- DATA_W, 32, sample/word width; multiple of 8.
- CNT_W, 32, width of sample counter and number_samples.
- SETTLE_CYC, 2, mux settle cycles after select changes before mic_data is captured; >=1.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset.
- AM_ADDR  out  ADDR_W  write byte address.
- AM_BURSTCOUNT  out  3  constant 1.
- AM_WRITE  out  1  write request.
- AM_WRITEDATA  out  DATA_W  captured sample.
- AM_BYTEENABLE  out  DATA_W/8  all ones.
- AM_WAITREQUEST  in  1  slave stall.
- mic_data  in  DATA_W  muxed mic sample.
- select  out  clog2(NUM_CH)  mic mux select.
- read_ready  in  1  new frame available (level).
- start  in  1  run request (level).
- start_address  in  ADDR_W  buffer base.
- number_samples  in  CNT_W  samples per channel.
- FINISHED  out  1  capture complete.
- overrun_count  out  16  see Optional Feature.

Behaviour:
- Reset (synchronous, active-high, also mid-transfer): state IDLE; AM_WRITE=0, AM_ADDR=0, AM_WRITEDATA=0, select=0, FINISHED=0, overrun_count=0. All counters cleared. An in-flight write is dropped.
- States: IDLE, WAIT_RDY, SEL, WR, FIN.
- IDLE, start=1: latch N=number_samples and base=start_address, then:
  - per-channel address ptr[c] = base + c*N*(DATA_W/8), truncated to ADDR_W;
  - ch=0, sample=0;
  - if N==0, go to FIN; else go to WAIT_RDY.
- WAIT_RDY: read_ready=1 -> SEL with ch=0. Otherwise stay.
- SEL:
  - select=ch; settle counter runs SETTLE_CYC cycles.
  - On the last settle cycle, register mic_data into AM_WRITEDATA and move to WR.
- WR:
  - AM_WRITE=1, AM_ADDR=ptr[ch]; address and data held stable while AM_WAITREQUEST=1.
  - On the cycle AM_WAITREQUEST=0, the write is accepted: ptr[ch] += DATA_W/8 and AM_WRITE drops the next cycle.
  - If ch<NUM_CH-1: ch++ and go to SEL.
  - Otherwise: sample++; go to FIN if sample==N, else WAIT_RDY.
- Minimum per-channel cost: SETTLE_CYC+1 cycles. Frame cost is at least NUM_CH*(SETTLE_CYC+1).
- FIN: FINISHED=1 and AM_WRITE=0; held while start=1. start=0 -> IDLE; FINISHED clears on that transition.
- start dropping during WAIT_RDY/SEL/WR does not abort; the run completes to FIN and then returns to IDLE.
- read_ready held high: frames run back to back. read_ready level is ignored outside WAIT_RDY.
- select returns to 0 in IDLE and FIN.
- Exactly NUM_CH*N writes per run. Write order: sample-major, channel-minor.

Optional Feature:
- Macro: MIC_DMA_OVERRUN_EN.
- Defined:
  - Count rising edges of read_ready seen while state is SEL or WR; these are frames lost because the previous frame was not yet written.
  - overrun_count is 16-bit and saturates at 0xFFFF.
  - Cleared in IDLE when start=1 and on reset.
- Undefined: no edge detector or counter; overrun_count tied to 0.

Test Plan:
- NUM_CH=4, N=2, base=0x1000, AM_WAITREQUEST=0, read_ready pulsed twice -> 8 writes:
  - addresses 0x1000, 0x1008, 0x1010, 0x1018, 0x1004, 0x100C, 0x1014, 0x101C;
  - select 0,1,2,3,0,1,2,3;
  - FINISHED=1 after the 8th write and held until start=0.
- Same run with AM_WAITREQUEST high 3 cycles on every write -> AM_ADDR/AM_WRITEDATA stable across the stall; still exactly 8 writes, same addresses.
- N=0, start=1 -> FIN on the next cycle; no AM_WRITE pulses; FINISHED=1.
- Assert RESET during WR of sample 1, ch 2 -> next cycle AM_WRITE=0, FINISHED=0, state IDLE. New start=1 with base=0x2000 restarts at 0x2000.
- With MIC_DMA_OVERRUN_EN: 3 read_ready rising edges during a frame's SEL/WR phases -> overrun_count=3. Without the macro -> overrun_count=0.
- SETTLE_CYC=2, mic_data changes 1 cycle after select changes -> AM_WRITEDATA equals the post-change value for every channel.

Source files
------------

// File: rtl/mic_dma_multi.sv
`default_nettype none
// ============================================================================
// Module   : mic_dma_multi
// Brief    : Multi-channel microphone capture DMA. Steps the mic mux through
//            NUM_CH channels per frame, captures one word per channel and
//            writes it through an Avalon-MM master into a per-channel
//            contiguous buffer (sample-major, channel-minor write order).
// Options  : MIC_DMA_OVERRUN_EN - count read_ready rising edges that arrive
//            while a frame is still being captured/written.
// Revision : 1.0 - initial release
// ============================================================================
module mic_dma_multi #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32,
  parameter int SETTLE_CYC = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  output logic [ADDR_W-1:0]       AM_ADDR,
  output logic [2:0]              AM_BURSTCOUNT,
  output logic                    AM_WRITE,
  output logic [DATA_W-1:0]       AM_WRITEDATA,
  output logic [DATA_W/8-1:0]     AM_BYTEENABLE,
  input  logic                    AM_WAITREQUEST,
  input  logic [DATA_W-1:0]       mic_data,
  output logic [$clog2(NUM_CH)-1:0] select,
  input  logic                    read_ready,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_address,
  input  logic [CNT_W-1:0]        number_samples,
  output logic                    FINISHED,
  output logic [15:0]             overrun_count
);

  localparam int              c_SEL_W   = $clog2(NUM_CH);
  localparam int              c_SET_W   = $clog2(SETTLE_CYC + 1);
  localparam logic [ADDR_W-1:0] c_BYTES_A = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_SEL      = 3'd2,
    S_WR       = 3'd3,
    S_FIN      = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_SEL_W-1:0]  r_ch;
  logic [CNT_W-1:0]    r_n;
  logic [CNT_W-1:0]    r_sample;
  logic [c_SET_W-1:0]  r_settle;
  logic [ADDR_W-1:0]   r_ptr [NUM_CH];
  logic [DATA_W-1:0]   r_wdata;

  logic                w_settle_done;
  logic                w_last_ch;
  logic                w_last_sample;
  logic [ADDR_W-1:0]   w_stride;

  assign w_settle_done = (r_settle == c_SET_W'(SETTLE_CYC - 1));
  assign w_last_ch     = (r_ch == c_SEL_W'(NUM_CH - 1));
  assign w_last_sample = ((r_sample + CNT_W'(1)) == r_n);
  // Per-channel buffer size in bytes; modular arithmetic gives the
  // ADDR_W truncation of base + c*N*bytes for free.
  assign w_stride      = ADDR_W'(number_samples) * c_BYTES_A;

  assign AM_BURSTCOUNT = 3'd1;
  assign AM_BYTEENABLE = '1;
  assign AM_WRITEDATA  = r_wdata;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and Moore-style bus/mux outputs.
  always_comb begin
    w_next   = r_state;
    AM_WRITE = 1'b0;
    AM_ADDR  = '0;
    select   = '0;
    FINISHED = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (number_samples == '0) ? S_FIN : S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        select = r_ch;
        if (read_ready) w_next = S_SEL;
      end
      S_SEL: begin
        select = r_ch;
        if (w_settle_done) w_next = S_WR;
      end
      S_WR: begin
        select   = r_ch;
        AM_WRITE = 1'b1;
        AM_ADDR  = r_ptr[r_ch];
        if (!AM_WAITREQUEST) begin
          if (!w_last_ch)         w_next = S_SEL;
          else if (w_last_sample) w_next = S_FIN;
          else                    w_next = S_WAIT_RDY;
        end
      end
      S_FIN: begin
        FINISHED = 1'b1;
        if (!start) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Run parameters, channel/sample/settle counters, address pointers, data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ch     <= '0;
      r_n      <= '0;
      r_sample <= '0;
      r_settle <= '0;
      r_wdata  <= '0;
      for (int i = 0; i < NUM_CH; i++) r_ptr[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n      <= number_samples;
            r_ch     <= '0;
            r_sample <= '0;
            r_settle <= '0;
            for (int i = 0; i < NUM_CH; i++)
              r_ptr[i] <= start_address + w_stride * ADDR_W'(i);
          end
        end
        S_WAIT_RDY: begin
          if (read_ready) begin
            r_ch     <= '0;
            r_settle <= '0;
          end
        end
        S_SEL: begin
          // Capture on the final settle cycle so the mux has had
          // SETTLE_CYC cycles to propagate the newly selected mic.
          if (w_settle_done) begin
            r_wdata  <= mic_data;
            r_settle <= '0;
          end else begin
            r_settle <= r_settle + c_SET_W'(1);
          end
        end
        S_WR: begin
          if (!AM_WAITREQUEST) begin
            r_ptr[r_ch] <= r_ptr[r_ch] + c_BYTES_A;
            if (!w_last_ch) begin
              r_ch <= r_ch + c_SEL_W'(1);
            end else begin
              r_ch     <= '0;
              r_sample <= r_sample + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MIC_DMA_OVERRUN_EN
  logic        r_rr_q;
  logic [15:0] r_ovr;

  // Frames announced while the previous one is still in SEL/WR are lost;
  // count them with a saturating counter, cleared when a new run starts.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rr_q <= 1'b0;
      r_ovr  <= '0;
    end else begin
      r_rr_q <= read_ready;
      if (r_state == S_IDLE && start)
        r_ovr <= '0;
      else if ((r_state == S_SEL || r_state == S_WR) && read_ready && !r_rr_q
               && r_ovr != 16'hFFFF)
        r_ovr <= r_ovr + 16'd1;
    end
  end

  assign overrun_count = r_ovr;
`else
  assign overrun_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mic_dma_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic_dma_multi
// Brief    : Randomized scoreboard bench for mic_dma_multi. Expected writes
//            are computed from buffer layout rules and queued per run; a
//            monitor pops and compares each accepted Avalon write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mic_dma_multi;

  localparam int NUM_CH = 4;
  localparam int BYTES  = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] AM_ADDR;
  logic [2:0]  AM_BURSTCOUNT;
  logic        AM_WRITE;
  logic [31:0] AM_WRITEDATA;
  logic [3:0]  AM_BYTEENABLE;
  logic        AM_WAITREQUEST;
  logic [31:0] mic_data;
  logic [1:0]  select;
  logic        read_ready = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_address = '0;
  logic [31:0] number_samples = '0;
  logic        FINISHED;
  logic [15:0] overrun_count;

  always #5 CLK = ~CLK;

  mic_dma_multi #(
    .NUM_CH(NUM_CH), .ADDR_W(32), .DATA_W(32), .CNT_W(32), .SETTLE_CYC(2)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .AM_ADDR(AM_ADDR), .AM_BURSTCOUNT(AM_BURSTCOUNT), .AM_WRITE(AM_WRITE),
    .AM_WRITEDATA(AM_WRITEDATA), .AM_BYTEENABLE(AM_BYTEENABLE),
    .AM_WAITREQUEST(AM_WAITREQUEST),
    .mic_data(mic_data), .select(select), .read_ready(read_ready),
    .start(start), .start_address(start_address),
    .number_samples(number_samples), .FINISHED(FINISHED),
    .overrun_count(overrun_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          sel;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          writes_seen = 0;
  int          cur_frame = 0;
  logic [31:0] run_salt = '0;
  int          wait_mode = 0;  // 0 never, 1 random, 2 three-cycle stall, 3 always

  // Value the mic array presents for channel c of frame s.
  function automatic logic [31:0] word_of(input logic [31:0] salt, input int s, input int c);
    return salt ^ (32'(s) << 16) ^ (32'(c) << 4) ^ 32'(c);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Mic front end: output follows the select seen one cycle earlier.
  initial begin
    int last_sel = 0;
    mic_data = '0;
    forever begin
      @(posedge CLK); #1;
      mic_data = word_of(run_salt, cur_frame, last_sel);
      last_sel = int'(select);
    end
  end

  // Slave stall generator.
  initial begin
    int stall = 0;
    AM_WAITREQUEST = 1'b0;
    forever begin
      @(posedge CLK); #2;
      case (wait_mode)
        0: AM_WAITREQUEST = 1'b0;
        1: AM_WAITREQUEST = 1'($urandom_range(0, 1));
        2: begin
          if (AM_WRITE && stall < 3) begin AM_WAITREQUEST = 1'b1; stall++; end
          else begin AM_WAITREQUEST = 1'b0; stall = 0; end
        end
        default: AM_WAITREQUEST = 1'b1;
      endcase
    end
  end

  // Monitor: stall stability and in-order write comparison.
  initial begin
    logic        stall_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    exp_t        e;
    forever begin
      @(negedge CLK);
      if (RESET || !AM_WRITE) begin
        stall_valid = 1'b0;
      end else begin
        if (stall_valid) begin
          checks++;
          if (AM_ADDR !== st_addr || AM_WRITEDATA !== st_data) begin
            failures++;
            $display("FAIL stall_hold actual=%h/%h required=%h/%h",
                     AM_ADDR, AM_WRITEDATA, st_addr, st_data);
          end
        end
        if (AM_WAITREQUEST) begin
          stall_valid = 1'b1;
          st_addr = AM_ADDR;
          st_data = AM_WRITEDATA;
        end else begin
          stall_valid = 1'b0;
          writes_seen++;
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL extra_write actual addr=%h required none", AM_ADDR);
          end else begin
            e = sb_q.pop_front();
            if (AM_ADDR !== e.addr || AM_WRITEDATA !== e.data || int'(select) != e.sel
                || AM_BURSTCOUNT !== 3'd1 || AM_BYTEENABLE !== 4'hF) begin
              failures++;
              $display("FAIL write actual addr=%h data=%h sel=%0d bc=%0d be=%h required addr=%h data=%h sel=%0d bc=1 be=f",
                       AM_ADDR, AM_WRITEDATA, select, AM_BURSTCOUNT, AM_BYTEENABLE,
                       e.addr, e.data, e.sel);
            end
          end
        end
      end
    end
  end

  task automatic wait_writes(input int target, input int budget);
    int n = 0;
    while (writes_seen < target && n < budget) begin
      @(negedge CLK); #1;
      n++;
    end
    chk("write_count_reached", 64'(writes_seen >= target), 64'd1);
  endtask

  task automatic tick();
    @(negedge CLK); #1;
  endtask

  task automatic do_run(input logic [31:0] base, input int n, input int wmode,
                        input bit drop_start, input bit burst);
    int exp_ovr;
    wait_mode = wmode;
    run_salt  = $urandom;
    for (int s = 0; s < n; s++)
      for (int c = 0; c < NUM_CH; c++) begin
        exp_t e;
        e.addr = base + 32'(c * n * BYTES) + 32'(s * BYTES);
        e.data = word_of(run_salt, s, c);
        e.sel  = c;
        sb_q.push_back(e);
      end
    writes_seen    = 0;
    start_address  = base;
    number_samples = 32'(n);
    start          = 1'b1;
    tick();
    if (n == 0) begin
      chk("n0_finished", 64'(FINISHED), 64'd1);
      chk("n0_no_write", 64'(AM_WRITE), 64'd0);
    end
    for (int s = 0; s < n; s++) begin
      if (s > 0) begin
        wait_writes(NUM_CH * s, 400);
        tick();
      end
      cur_frame = s;
      if (!burst) repeat ($urandom_range(0, 2)) tick();
      read_ready = 1'b1;
      repeat (burst ? 1 : $urandom_range(1, 3)) tick();
      read_ready = 1'b0;
      if (drop_start && s == 0) start = 1'b0;
      if (burst && s == 0)
        repeat (3) begin
          tick(); read_ready = 1'b1;
          tick(); read_ready = 1'b0;
        end
    end
    if (n > 0) begin
      wait_writes(NUM_CH * n, 600);
      tick();
      chk("fin_set", 64'(FINISHED), 64'd1);
      chk("fin_select0", 64'(select), 64'd0);
      if (!drop_start) begin
        repeat ($urandom_range(1, 3)) tick();
        chk("fin_held", 64'(FINISHED), 64'd1);
      end
    end
    start = 1'b0;
    if (!drop_start || n == 0) tick();
    tick();
    chk("fin_cleared", 64'(FINISHED), 64'd0);
`ifdef MIC_DMA_OVERRUN_EN
    exp_ovr = burst ? 3 : 0;
`else
    exp_ovr = 0;
`endif
    chk("overrun_count", 64'(overrun_count), 64'(exp_ovr));
    chk("queue_drained", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_r;
    repeat (3) @(negedge CLK);
    #1;
    chk("reset_state",
        {AM_WRITE, FINISHED, select, AM_BURSTCOUNT, AM_BYTEENABLE, overrun_count},
        {1'b0, 1'b0, 2'd0, 3'd1, 4'hF, 16'h0});
    chk("reset_addr_data", {AM_ADDR, AM_WRITEDATA}, 64'd0);
    RESET = 1'b0;
    tick();

    do_run(32'h1000, 2, 0, 1'b0, 1'b0);
    do_run(32'h1000, 2, 2, 1'b0, 1'b0);
    do_run(32'h0000_5000, 0, 0, 1'b0, 1'b0);
    do_run(32'h0000_7000, 2, 0, 1'b0, 1'b1);
    do_run(32'hFFFF_FFF8, 2, 1, 1'b1, 1'b0);

    // Reset while sample 1, channel 2 is stalled in WR.
    begin
      exp_t e;
      int   n = 0;
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < NUM_CH; c++) begin
          e.addr = 32'h3000 + 32'(c * 2 * BYTES) + 32'(s * BYTES);
          e.data = word_of(run_salt, s, c);
          e.sel  = c;
          sb_q.push_back(e);
        end
      wait_mode = 0; writes_seen = 0;
      start_address = 32'h3000; number_samples = 2; start = 1'b1;
      tick();
      cur_frame = 0; read_ready = 1'b1; tick(); read_ready = 1'b0;
      wait_writes(4, 400);
      tick();
      cur_frame = 1; read_ready = 1'b1; tick(); read_ready = 1'b0;
      wait_writes(6, 400);
      wait_mode = 3;
      while (!(AM_WRITE && AM_ADDR == 32'h3000 + 32'(2 * 2 * BYTES) + 32'(BYTES)) && n < 100) begin
        tick(); n++;
      end
      chk("reached_s1c2_write", 64'(AM_WRITE), 64'd1);
      RESET = 1'b1; start = 1'b0;
      tick();
      chk("midrun_reset", {AM_WRITE, FINISHED, select, overrun_count}, 20'd0);
      chk("midrun_reset_bus", {AM_ADDR, AM_WRITEDATA}, 64'd0);
      RESET = 1'b0; wait_mode = 0;
      sb_q.delete();
      tick();
    end
    do_run(32'h2000, 1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      n_r = $urandom_range(1, 3);
      do_run({14'd0, 16'($urandom), 2'b00}, n_r, $urandom_range(0, 2),
             1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
